// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage of the single-issue RISC-V core.
//
// Owns the program counter, fetches 32-bit words from instruction memory over
// a request/response handshake and presents them to decode through the IF/ID
// register. A one-entry skid buffer absorbs a response that arrives while
// decode is stalled; taken-branch redirects flush IF/ID and the skid and
// discard any fetch still in flight.
//
// Ports
//   clk            core clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   imem_req       fetch request
//   imem_addr      fetch byte address (held while a request is pending)
//   imem_rvalid    response strobe, completes the current request
//   imem_rdata     instruction word, valid with imem_rvalid
//   id_stall       decode cannot accept; IF/ID holds
//   branch_taken   redirect request (one-cycle pulse)
//   branch_target  redirect byte address
//   if_valid       if_instr/if_pc hold a real instruction
//   if_instr       instruction to decode (NOP_INSTR when not valid)
//   if_pc          address of if_instr
//   if_fault       sticky misaligned-redirect flag
//
// Optional feature: define IF_MISALIGN_CHECK_EN to turn a redirect to a
// non-word-aligned target into a sticky fault that halts fetching until reset.
// Without it the low two target bits are ignored and if_fault is tied low.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
`ifdef IF_MISALIGN_CHECK_EN
    ST_DROP  = 3'd3,
    ST_HALT  = 3'd4
`else
    ST_DROP  = 3'd3
`endif
  } state_t;

  state_t      state_r, state_nx_s, exit_s;
  logic [31:0] pc_r, pc_nx_s;
  logic [31:0] addr_r, addr_nx_s;
  logic        req_r, req_nx_s;
  logic        ifv_r, ifv_nx_s;
  logic [31:0] ifi_r, ifi_nx_s;
  logic [31:0] ifp_r, ifp_nx_s;
  logic        skv_r, skv_nx_s;
  logic [31:0] ski_r, ski_nx_s;
  logic [31:0] skp_r, skp_nx_s;
  logic        slot_free_s;
  logic        redirect_s;
  logic        misalign_s;
  logic        halted_s;
  logic [31:0] target_s;

`ifdef IF_MISALIGN_CHECK_EN
  logic fault_r;
  logic halting_s;

  assign misalign_s = (branch_target[1:0] != 2'b00);
  assign target_s   = branch_target;
  assign halted_s   = (state_r == ST_HALT);
  // Once faulted, leaving DROP (or a redirect with nothing pending) ends in HALT.
  assign halting_s  = fault_r | (redirect_s & misalign_s);
  assign exit_s     = halting_s ? ST_HALT : ST_FETCH;
  assign if_fault   = fault_r;

  // Sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (redirect_s && misalign_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  assign misalign_s = 1'b0;
  assign target_s   = branch_target & 32'hFFFF_FFFC;
  assign halted_s   = 1'b0;
  assign exit_s     = ST_FETCH;
  assign if_fault   = 1'b0;
`endif

  // A halted stage ignores further redirects.
  assign redirect_s  = branch_taken & ~halted_s;
  assign slot_free_s = ~ifv_r | ~id_stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a redirect overrides stall and response handling
  always_comb begin
    state_nx_s = state_r;
    if (redirect_s) begin
      // req_r high means a request is outstanding; its late response must be dropped.
      if (req_r && !imem_rvalid) begin
        state_nx_s = ST_DROP;
      end else begin
        state_nx_s = exit_s;
      end
    end else begin
      case (state_r)
        ST_IDLE:  state_nx_s = ST_FETCH;
        ST_FETCH: begin
          if (imem_rvalid && !slot_free_s) begin
            state_nx_s = ST_HOLD;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            state_nx_s = ST_FETCH;
          end else begin
            state_nx_s = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state_nx_s = exit_s;
          end else begin
            state_nx_s = ST_DROP;
          end
        end
`ifdef IF_MISALIGN_CHECK_EN
        ST_HALT:  state_nx_s = ST_HALT;
`endif
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: pc, fetch address/request, IF/ID and skid
  always_comb begin
    pc_nx_s  = pc_r;
    ifv_nx_s = ifv_r;
    ifi_nx_s = ifi_r;
    ifp_nx_s = ifp_r;
    skv_nx_s = skv_r;
    ski_nx_s = ski_r;
    skp_nx_s = skp_r;
    if (redirect_s) begin
      if (misalign_s) begin
        pc_nx_s = pc_r;
      end else begin
        pc_nx_s = target_s;
      end
      ifv_nx_s = 1'b0;
      ifi_nx_s = NOP_INSTR;
      skv_nx_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_rvalid) begin
            pc_nx_s = pc_r + 32'd4;
            if (slot_free_s) begin
              ifv_nx_s = 1'b1;
              ifi_nx_s = imem_rdata;
              ifp_nx_s = addr_r;
            end else begin
              skv_nx_s = 1'b1;
              ski_nx_s = imem_rdata;
              skp_nx_s = addr_r;
            end
          end else if (ifv_r && !id_stall) begin
            ifv_nx_s = 1'b0;
            ifi_nx_s = NOP_INSTR;
          end else begin
            ifv_nx_s = ifv_r;
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            ifv_nx_s = skv_r;
            ifi_nx_s = ski_r;
            ifp_nx_s = skp_r;
            skv_nx_s = 1'b0;
          end else begin
            skv_nx_s = skv_r;
          end
        end
        default: ifv_nx_s = ifv_r;
      endcase
    end
    // While dropping, the stale address stays on the bus until its response lands.
    if (state_nx_s == ST_DROP) begin
      addr_nx_s = addr_r;
    end else begin
      addr_nx_s = pc_nx_s;
    end
    req_nx_s = (state_nx_s == ST_FETCH) || (state_nx_s == ST_DROP);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r   <= RESET_PC;
      addr_r <= RESET_PC;
      req_r  <= 1'b0;
      ifv_r  <= 1'b0;
      ifi_r  <= NOP_INSTR;
      ifp_r  <= 32'h0000_0000;
      skv_r  <= 1'b0;
      ski_r  <= NOP_INSTR;
      skp_r  <= 32'h0000_0000;
    end else begin
      pc_r   <= pc_nx_s;
      addr_r <= addr_nx_s;
      req_r  <= req_nx_s;
      ifv_r  <= ifv_nx_s;
      ifi_r  <= ifi_nx_s;
      ifp_r  <= ifp_nx_s;
      skv_r  <= skv_nx_s;
      ski_r  <= ski_nx_s;
      skp_r  <= skp_nx_s;
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = addr_r;
  assign if_valid  = ifv_r;
  assign if_instr  = ifi_r;
  assign if_pc     = ifp_r;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A behavioural instruction memory with configurable wait states and a
// response budget drives the fetch port. Expected fetch addresses are queued
// when each directed step is set up; a monitor pops and compares every
// instruction decode consumes (if_valid && !id_stall, no redirect).
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int mem_lat = 0;
  int mem_budget = 0;
  int mem_cnt = 0;
  logic sb_en = 1'b0;
  logic [31:0] exp_q[$];

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is tagged with its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk32(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic chk1(input string t, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", t, obs, exp);
    end
  endtask

  // Instruction memory: responds after mem_lat wait cycles, at most mem_budget times.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mem_cnt = 0;
      imem_rvalid = 1'b0;
    end else begin
      if (imem_rvalid) begin
        mem_budget--;
        mem_cnt = imem_req ? 1 : 0;
      end else begin
        mem_cnt = imem_req ? mem_cnt + 1 : 0;
      end
      imem_rvalid = imem_req && (mem_budget > 0) && (mem_cnt > mem_lat);
      imem_rdata = imem_rvalid ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: every instruction decode takes must be the next expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && sb_en && if_valid && !id_stall && !branch_taken) begin
      n_chk++;
      assert (exp_q.size() != 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sb_underflow: observed pc %h expected no further instruction", if_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk32("sb_pc", if_pc, e);
        chk32("sb_instr", if_instr, mem_word(e));
      end
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input int lat, input int budget);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_en = 1'b0;
    id_stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    mem_lat = lat;
    mem_budget = budget;
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string t, input int max);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk32({t, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk1({t, "_idle_valid"}, if_valid, 1'b0);
  endtask

  initial begin
    int k;
    // Reset values
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", if_valid, 1'b0);
    chk32("rst_instr", if_instr, NOP);
    chk32("rst_pc", if_pc, 32'h0);
    chk1("rst_fault", if_fault, 1'b0);

    // Zero-wait streaming
    start_test(0, 6);
    push_seq(32'h0, 6);
    sb_en = 1'b1;
    @(negedge clk);
    chk1("t1_req", imem_req, 1'b1);
    chk32("t1_addr0", imem_addr, 32'h0);
    chk1("t1_valid0", if_valid, 1'b0);
    chk32("t1_nop", if_instr, NOP);
    @(negedge clk);
    chk32("t1_pc0", if_pc, 32'h0);
    chk32("t1_instr0", if_instr, mem_word(32'h0));
    chk32("t1_addr4", imem_addr, 32'h4);
    @(negedge clk);
    chk32("t1_pc4", if_pc, 32'h4);
    @(negedge clk);
    chk32("t1_pc8", if_pc, 32'h8);
    drain("t1", 20);

    // Three-cycle memory latency
    start_test(2, 4);
    push_seq(32'h0, 4);
    sb_en = 1'b1;
    @(negedge clk);
    chk32("t2_addr_w1", imem_addr, 32'h0);
    @(negedge clk);
    chk32("t2_addr_w2", imem_addr, 32'h0);
    chk1("t2_valid_w2", if_valid, 1'b0);
    @(negedge clk);
    chk32("t2_addr_w3", imem_addr, 32'h0);
    @(negedge clk);
    chk1("t2_valid_a", if_valid, 1'b1);
    chk32("t2_pc0", if_pc, 32'h0);
    chk32("t2_addr4", imem_addr, 32'h4);
    @(negedge clk);
    chk1("t2_gap1", if_valid, 1'b0);
    @(negedge clk);
    chk1("t2_gap2", if_valid, 1'b0);
    chk1("t2_req", imem_req, 1'b1);
    @(negedge clk);
    chk32("t2_pc4", if_pc, 32'h4);
    drain("t2", 20);

    // Reset asserted while a request is pending
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    chk32("mid_rst_addr", imem_addr, 32'h0);
    chk32("mid_rst_instr", if_instr, NOP);

    // Decode stall with skid capture
    start_test(0, 6);
    push_seq(32'h0, 6);
    sb_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    drv();
    id_stall = 1'b1;
    @(negedge clk);
    chk32("t3_pc_held", if_pc, 32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t3_req_off", imem_req, 1'b0);
      chk32("t3_pc_hold", if_pc, 32'h4);
    end
    drv();
    id_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk32("t3_pc_skid", if_pc, 32'h8);
    chk32("t3_addr_c", imem_addr, 32'hC);
    drain("t3", 20);

    // Redirect while a fetch is pending without response
    start_test(0, 8);
    push_seq(32'h0, 8);
    push_seq(32'h100, 3);
    sb_en = 1'b1;
    k = 0;
    while (exp_q.size() > 3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk32("t4_pre_drain", 32'(exp_q.size()), 32'd3);
    @(negedge clk);
    chk32("t4_pend_addr", imem_addr, 32'h20);
    chk1("t4_pend_valid", if_valid, 1'b0);
    drv();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    drv();
    branch_taken = 1'b0;
    @(negedge clk);
    chk32("t4_drop_addr", imem_addr, 32'h20);
    chk1("t4_drop_req", imem_req, 1'b1);
    chk32("t4_drop_instr", if_instr, NOP);
    mem_budget = 4;
    @(negedge clk);
    chk32("t4_drop_addr2", imem_addr, 32'h20);
    @(negedge clk);
    chk32("t4_tgt_addr", imem_addr, 32'h100);
    chk1("t4_discard", if_valid, 1'b0);
    @(negedge clk);
    chk32("t4_tgt_pc", if_pc, 32'h100);
    drain("t4", 20);

    // Redirect coinciding with stall and response, then with a full skid
    start_test(0, 7);
    drv();
    drv();
    id_stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    @(negedge clk);
    chk1("t5_full", if_valid, 1'b1);
    drv();
    branch_taken = 1'b0;
    @(negedge clk);
    chk1("t5_flush", if_valid, 1'b0);
    chk32("t5_flush_instr", if_instr, NOP);
    chk32("t5_addr", imem_addr, 32'h200);
    @(negedge clk);
    chk32("t5_pc200", if_pc, 32'h200);
    drv();
    branch_taken = 1'b1;
    branch_target = 32'h300;
    @(negedge clk);
    chk1("t5_hold_req", imem_req, 1'b0);
    chk32("t5_hold_pc", if_pc, 32'h200);
    drv();
    branch_taken = 1'b0;
    id_stall = 1'b0;
    push_seq(32'h300, 3);
    sb_en = 1'b1;
    @(negedge clk);
    chk1("t5_flush2", if_valid, 1'b0);
    chk32("t5_addr300", imem_addr, 32'h300);
    drain("t5", 20);

    // Misaligned redirect target
    start_test(0, 20);
    drv();
    drv();
    drv();
    branch_taken = 1'b1;
    branch_target = 32'h102;
    drv();
    branch_taken = 1'b0;
    @(negedge clk);
`ifdef IF_MISALIGN_CHECK_EN
    chk1("t6_fault", if_fault, 1'b1);
    chk1("t6_req_off", imem_req, 1'b0);
    chk1("t6_valid", if_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t6_halt_req", imem_req, 1'b0);
      chk1("t6_sticky", if_fault, 1'b1);
    end
    start_test(0, 4);
    @(negedge clk);
    chk1("t6_fault_clr", if_fault, 1'b0);
    chk1("t6_req_on", imem_req, 1'b1);
`else
    chk32("t6_addr", imem_addr, 32'h100);
    chk1("t6_req", imem_req, 1'b1);
    chk1("t6_valid", if_valid, 1'b0);
    chk1("t6_nofault", if_fault, 1'b0);
    @(negedge clk);
    chk32("t6_pc", if_pc, 32'h100);
    chk32("t6_instr", if_instr, mem_word(32'h100));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
